// File: rtl/uart_receiver_if.sv
// CPU-side register port of the UART receiver: pop/clear strobes in,
// FIFO head, occupancy and sticky error flags out.
interface uart_receiver_if #(
  parameter int FIFO_LOG2 = 2
);
  logic                 i_rd;
  logic                 i_clr_err;
  logic [7:0]           o_data;
  logic                 o_valid;
  logic [FIFO_LOG2:0]   o_count;
  logic                 o_frame_err;
  logic                 o_overrun;

  modport master (
    output i_rd, i_clr_err,
    input  o_data, o_valid, o_count, o_frame_err, o_overrun
  );

  modport slave (
    input  i_rd, i_clr_err,
    output o_data, o_valid, o_count, o_frame_err, o_overrun
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: oversampling framer on RXD feeding a small byte FIFO
// drained by the CPU, with sticky framing-error and overrun flags.
module uart_receiver #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD_RATE   = 1000000,
  parameter int FIFO_LOG2   = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            RXD,
  uart_receiver_if.slave  bus
);
  localparam int DIV   = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF  = DIV / 2;
  localparam int CW    = $clog2(DIV);
  localparam int DEPTH = 1 << FIFO_LOG2;

  localparam logic [CW-1:0]        CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0]        CNT_FULL = CW'(DIV - 1);
  localparam logic [FIFO_LOG2:0]   CNT_MAX  = (FIFO_LOG2 + 1)'(DEPTH);

  if (DIV < 4) begin : g_div_check
    $error("uart_receiver: CLK_FREQ_HZ/BAUD_RATE must be at least 4");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t              state;
  logic                sync1;
  logic                rx_s;
  logic [CW-1:0]       cnt;
  logic [2:0]          idx;
  logic [7:0]          sh;

  logic [7:0]          mem [DEPTH];
  logic [FIFO_LOG2-1:0] wptr;
  logic [FIFO_LOG2-1:0] rptr;
  logic [FIFO_LOG2:0]  count;
  logic                frame_err;
  logic                overrun;

  logic stop_edge;
  logic push_ok;
  logic pop;
  logic full;
  logic push;
  logic overrun_set;
  logic frame_set;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= RXD;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            cnt   <= CNT_HALF;
            state <= S_START;
          end
        end
        S_START: begin
          if (cnt == '0) begin
            if (!rx_s) begin
              cnt   <= CNT_FULL;
              idx   <= '0;
              state <= S_DATA;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == '0) begin
            sh  <= {rx_s, sh[7:1]};
            cnt <= CNT_FULL;
            if (idx == 3'd7) state <= S_STOP;
            else             idx   <= idx + 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == '0) state <= rx_s ? S_IDLE : S_BREAK;
          else           cnt   <= cnt - 1'b1;
        end
        S_BREAK: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A full FIFO still accepts the byte when the CPU pops on the same edge.
  assign stop_edge   = (state == S_STOP) && (cnt == '0);
  assign push_ok     = stop_edge && rx_s;
  assign frame_set   = stop_edge && !rx_s;
  assign pop         = bus.i_rd && (count != '0);
  assign full        = (count == CNT_MAX);
  assign push        = push_ok && (!full || pop);
  assign overrun_set = push_ok && full && !pop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr] <= sh;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      frame_err <= frame_set   | (frame_err & ~bus.i_clr_err);
      overrun   <= overrun_set | (overrun   & ~bus.i_clr_err);
    end
  end

  assign bus.o_data      = (count != '0) ? mem[rptr] : '0;
  assign bus.o_valid     = (count != '0);
  assign bus.o_count     = count;
  assign bus.o_frame_err = frame_err;
  assign bus.o_overrun   = overrun;
endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus randomized
// bursts scored against a queue model of the FIFO and sticky flags.
module tb_uart_receiver;
  localparam int DIV   = 100;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic resetn;
  logic RXD;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [2:0] cnt_pre, cnt_post;
  logic       valid_pre, valid_post;

  uart_receiver_if #(.FIFO_LOG2(2)) bus ();

  uart_receiver #(
    .CLK_FREQ_HZ(100000000),
    .BAUD_RATE  (1000000),
    .FIFO_LOG2  (2)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .RXD   (RXD),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one character starting right away; the stop bit is sampled by the
  // receiver on the 53rd edge of the stop phase.
  task automatic send_byte(input logic [7:0] b, input bit stop_bad, input bit rd_at_stop);
    RXD = 1'b0;
    repeat (DIV) tick();
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      repeat (DIV) tick();
    end
    if (stop_bad) begin
      RXD = 1'b0;
      repeat (300) tick();
      RXD = 1'b1;
      repeat (DIV) tick();
    end else begin
      RXD = 1'b1;
      for (int k = 1; k <= DIV; k++) begin
        tick();
        if (k == 52) begin
          cnt_pre   = bus.o_count;
          valid_pre = bus.o_valid;
          if (rd_at_stop) bus.i_rd = 1'b1;
        end
        if (k == 53) begin
          cnt_post   = bus.o_count;
          valid_post = bus.o_valid;
          bus.i_rd   = 1'b0;
        end
      end
    end
  endtask

  task automatic pop(output logic [7:0] d, output logic v);
    d = bus.o_data;
    v = bus.o_valid;
    bus.i_rd = 1'b1;
    tick();
    bus.i_rd = 1'b0;
  endtask

  task automatic clear_err();
    bus.i_clr_err = 1'b1;
    tick();
    bus.i_clr_err = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    RXD = 1'b1;
    bus.i_rd = 1'b0;
    bus.i_clr_err = 1'b0;
    repeat (3) tick();
    n_cmp++; if ({bus.o_data, bus.o_valid, bus.o_count, bus.o_frame_err, bus.o_overrun} !== 13'h0) begin
      n_err++; $display("FAIL reset_outputs: got data=%h valid=%b count=%0d fe=%b ov=%b, want all 0",
        bus.o_data, bus.o_valid, bus.o_count, bus.o_frame_err, bus.o_overrun);
    end
    resetn = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single();
    logic [7:0] d; logic v;
    send_byte(8'h55, 1'b0, 1'b0);
    n_cmp++; if ({valid_pre, cnt_pre} !== 4'b0_000) begin
      n_err++; $display("FAIL single_before_latency: got valid=%b count=%0d, want 0/0", valid_pre, cnt_pre);
    end
    n_cmp++; if ({valid_post, cnt_post} !== 4'b1_001) begin
      n_err++; $display("FAIL single_latency: got valid=%b count=%0d, want 1/1", valid_post, cnt_post);
    end
    n_cmp++; if (bus.o_data !== 8'h55) begin
      n_err++; $display("FAIL single_data: got %h want 55", bus.o_data);
    end
    pop(d, v);
    n_cmp++; if ({bus.o_valid, bus.o_data, bus.o_count} !== 12'h0) begin
      n_err++; $display("FAIL single_after_pop: got valid=%b data=%h count=%0d, want 0/00/0",
        bus.o_valid, bus.o_data, bus.o_count);
    end
  endtask

  task automatic test_glitch();
    RXD = 1'b0;
    repeat (20) tick();
    RXD = 1'b1;
    repeat (150) tick();
    n_cmp++; if ({bus.o_count, bus.o_frame_err, bus.o_overrun} !== 5'b0) begin
      n_err++; $display("FAIL glitch: got count=%0d fe=%b ov=%b, want 0/0/0",
        bus.o_count, bus.o_frame_err, bus.o_overrun);
    end
  endtask

  task automatic test_framing();
    logic [7:0] d; logic v;
    send_byte(8'hA3, 1'b1, 1'b0);
    n_cmp++; if ({bus.o_frame_err, bus.o_count} !== 4'b1_000) begin
      n_err++; $display("FAIL frame_err_set: got fe=%b count=%0d, want 1/0", bus.o_frame_err, bus.o_count);
    end
    send_byte(8'h3C, 1'b0, 1'b0);
    pop(d, v);
    n_cmp++; if ({v, d} !== 9'h13C) begin
      n_err++; $display("FAIL frame_recover: got valid=%b data=%h, want 1/3c", v, d);
    end
    n_cmp++; if (bus.o_frame_err !== 1'b1) begin
      n_err++; $display("FAIL frame_sticky: got %b want 1", bus.o_frame_err);
    end
    clear_err();
    n_cmp++; if (bus.o_frame_err !== 1'b0) begin
      n_err++; $display("FAIL frame_clear: got %b want 0", bus.o_frame_err);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] d; logic v;
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0, 1'b0);
    n_cmp++; if ({bus.o_overrun, bus.o_count} !== 4'b1_100) begin
      n_err++; $display("FAIL overrun_set: got ov=%b count=%0d, want 1/4", bus.o_overrun, bus.o_count);
    end
    for (int i = 1; i <= 4; i++) begin
      pop(d, v);
      n_cmp++; if ({v, d} !== {1'b1, 8'(i)}) begin
        n_err++; $display("FAIL overrun_pop%0d: got valid=%b data=%h, want 1/%h", i, v, d, 8'(i));
      end
    end
    n_cmp++; if (bus.o_valid !== 1'b0) begin
      n_err++; $display("FAIL overrun_empty: got valid=%b want 0", bus.o_valid);
    end
    clear_err();
    n_cmp++; if (bus.o_overrun !== 1'b0) begin
      n_err++; $display("FAIL overrun_clear: got %b want 0", bus.o_overrun);
    end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] d; logic v;
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 1'b0, 1'b0);
    send_byte(8'h14, 1'b0, 1'b1);
    n_cmp++; if ({cnt_pre, cnt_post, bus.o_overrun} !== 7'b100_100_0) begin
      n_err++; $display("FAIL full_pushpop: got pre=%0d post=%0d ov=%b, want 4/4/0",
        cnt_pre, cnt_post, bus.o_overrun);
    end
    for (int i = 1; i <= 4; i++) begin
      pop(d, v);
      n_cmp++; if ({v, d} !== {1'b1, 8'h10 + 8'(i)}) begin
        n_err++; $display("FAIL full_pop%0d: got valid=%b data=%h, want 1/%h", i, v, d, 8'h10 + 8'(i));
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b = 8'h7E;
    logic [7:0] d; logic v;
    send_byte(8'h42, 1'b0, 1'b0);
    RXD = 1'b0;
    repeat (DIV) tick();
    for (int i = 0; i < 3; i++) begin
      RXD = b[i];
      repeat (DIV) tick();
    end
    RXD = b[3];
    repeat (DIV / 2) tick();
    resetn = 1'b0;
    #2;
    n_cmp++; if ({bus.o_data, bus.o_valid, bus.o_count, bus.o_frame_err, bus.o_overrun} !== 13'h0) begin
      n_err++; $display("FAIL midreset_outputs: got data=%h valid=%b count=%0d, want all 0",
        bus.o_data, bus.o_valid, bus.o_count);
    end
    RXD = 1'b1;
    repeat (2 * DIV) tick();
    resetn = 1'b1;
    repeat (DIV) tick();
    send_byte(8'h81, 1'b0, 1'b0);
    repeat (DIV) tick();
    n_cmp++; if (bus.o_count !== 3'd1) begin
      n_err++; $display("FAIL midreset_count: got %0d want 1", bus.o_count);
    end
    pop(d, v);
    n_cmp++; if ({v, d, bus.o_valid, bus.o_frame_err, bus.o_overrun} !== {1'b1, 8'h81, 3'b000}) begin
      n_err++; $display("FAIL midreset_byte: got valid=%b data=%h after_valid=%b fe=%b ov=%b, want 1/81/0/0/0",
        v, d, bus.o_valid, bus.o_frame_err, bus.o_overrun);
    end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] b, d, exp_d;
    logic v;
    bit exp_fe, exp_ov, bad;
    int nb;
    for (int r = 0; r < 6; r++) begin
      exp_fe = 1'b0;
      exp_ov = 1'b0;
      nb = $urandom_range(1, 5);
      for (int j = 0; j < nb; j++) begin
        b   = 8'($urandom_range(0, 255));
        bad = ($urandom_range(0, 9) == 0);
        send_byte(b, bad, 1'b0);
        if (bad)                  exp_fe = 1'b1;
        else if (q.size() < DEPTH) q.push_back(b);
        else                      exp_ov = 1'b1;
      end
      n_cmp++; if ({bus.o_frame_err, bus.o_overrun, bus.o_count} !== {exp_fe, exp_ov, 3'(q.size())}) begin
        n_err++; $display("FAIL rand%0d_status: got fe=%b ov=%b count=%0d, want %b/%b/%0d",
          r, bus.o_frame_err, bus.o_overrun, bus.o_count, exp_fe, exp_ov, q.size());
      end
      while (q.size() > 0) begin
        exp_d = q.pop_front();
        pop(d, v);
        n_cmp++; if ({v, d} !== {1'b1, exp_d}) begin
          n_err++; $display("FAIL rand%0d_pop: got valid=%b data=%h, want 1/%h", r, v, d, exp_d);
        end
      end
      clear_err();
      n_cmp++; if ({bus.o_valid, bus.o_frame_err, bus.o_overrun} !== 3'b000) begin
        n_err++; $display("FAIL rand%0d_drained: got valid=%b fe=%b ov=%b, want 0/0/0",
          r, bus.o_valid, bus.o_frame_err, bus.o_overrun);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_framing();
    test_overrun();
    test_push_pop_full();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
